// File: rtl/btn_pulse_stretcher.sv
// Stretches the four single-cycle direction pulses into fixed-length LED levels
// and keeps the most recent direction plus a wrapping event count for status.
module btn_pulse_stretcher #(
    parameter int HOLD_CYCLES = 10_000_000,
    parameter int CNT_W       = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_pulse_L,
    input  logic       i_pulse_R,
    input  logic       i_pulse_U,
    input  logic       i_pulse_D,
    output logic       o_led_L,
    output logic       o_led_R,
    output logic       o_led_U,
    output logic       o_led_D,
    output logic       o_busy,
    output logic [1:0] o_last_dir,
    output logic [7:0] o_evt_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    function automatic logic [7:0] popcount4(input logic [3:0] p);
        popcount4 = 8'(p[0]) + 8'(p[1]) + 8'(p[2]) + 8'(p[3]);
    endfunction

    // Highest-indexed active pulse wins; no pulse keeps the previous value.
    function automatic logic [1:0] pick_dir(input logic [3:0] p, input logic [1:0] cur);
        if (p[3])      pick_dir = 2'd3;
        else if (p[2]) pick_dir = 2'd2;
        else if (p[1]) pick_dir = 2'd1;
        else if (p[0]) pick_dir = 2'd0;
        else           pick_dir = cur;
    endfunction

    logic [3:0]       pulse;
    state_t           state_q [4];
    state_t           state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [3:0]       led_d;
    logic [3:0]       led_q;
    logic             busy_q;
    logic [1:0]       dir_q;
    logic [7:0]       evt_q;

    assign pulse = {i_pulse_D, i_pulse_U, i_pulse_R, i_pulse_L};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            led_d[i]   = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (pulse[i]) begin
                        state_d[i] = HOLD;
                        cnt_d[i]   = RELOAD;
                    end
                end
                HOLD: begin
                    // A pulse on the expiry cycle reloads instead of dropping out.
                    if (pulse[i]) begin
                        cnt_d[i] = RELOAD;
                    end else if (cnt_q[i] == '0) begin
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            led_d[i] = (state_d[i] == HOLD);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            led_q  <= '0;
            busy_q <= 1'b0;
            dir_q  <= 2'd0;
            evt_q  <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            led_q  <= led_d;
            busy_q <= |led_d;
            dir_q  <= pick_dir(pulse, dir_q);
            evt_q  <= evt_q + popcount4(pulse);
        end
    end

    assign o_led_L    = led_q[0];
    assign o_led_R    = led_q[1];
    assign o_led_U    = led_q[2];
    assign o_led_D    = led_q[3];
    assign o_busy     = busy_q;
    assign o_last_dir = dir_q;
    assign o_evt_cnt  = evt_q;

endmodule

// File: tb/tb_btn_pulse_stretcher.sv
// Directed bench for btn_pulse_stretcher with HOLD_CYCLES = 4; expected states are
// queued by the stimulus and compared by a monitor on the falling clock edge.
module tb_btn_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_pulse_L = 1'b0;
    logic       i_pulse_R = 1'b0;
    logic       i_pulse_U = 1'b0;
    logic       i_pulse_D = 1'b0;
    logic       o_led_L, o_led_R, o_led_U, o_led_D, o_busy;
    logic [1:0] o_last_dir;
    logic [7:0] o_evt_cnt;

    btn_pulse_stretcher #(.HOLD_CYCLES(4), .CNT_W(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_pulse_L  (i_pulse_L),
        .i_pulse_R  (i_pulse_R),
        .i_pulse_U  (i_pulse_U),
        .i_pulse_D  (i_pulse_D),
        .o_led_L    (o_led_L),
        .o_led_R    (o_led_R),
        .o_led_U    (o_led_U),
        .o_led_D    (o_led_D),
        .o_busy     (o_busy),
        .o_last_dir (o_last_dir),
        .o_evt_cnt  (o_evt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        string      name;
        logic [3:0] leds;
        logic       busy;
        logic [1:0] dir;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Expected values describe the outputs after posedge number 'at'.
    task automatic expect_at(input int at, input string name, input logic [3:0] leds,
                             input logic [1:0] dir, input logic [7:0] cnt);
        exp_t e;
        e.at   = at;
        e.name = name;
        e.leds = leds;
        e.busy = (leds != 4'b0000);
        e.dir  = dir;
        e.cnt  = cnt;
        q.push_back(e);
    endtask

    task automatic goto(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] p);
        {i_pulse_D, i_pulse_U, i_pulse_R, i_pulse_L} = p;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= edge_n) begin
            cur = q.pop_front();
            checks = checks + 1;
            if (cur.at != edge_n ||
                {o_led_D, o_led_U, o_led_R, o_led_L} !== cur.leds ||
                o_busy !== cur.busy || o_last_dir !== cur.dir || o_evt_cnt !== cur.cnt) begin
                errors = errors + 1;
                $display("FAIL %s edge %0d (sampled at %0d): got leds=%b busy=%b dir=%0d cnt=%0d, want leds=%b busy=%b dir=%0d cnt=%0d",
                         cur.name, cur.at, edge_n, {o_led_D, o_led_U, o_led_R, o_led_L},
                         o_busy, o_last_dir, o_evt_cnt, cur.leds, cur.busy, cur.dir, cur.cnt);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        expect_at(1, "in_reset", 4'b0000, 2'd0, 8'd0);
        expect_at(5, "after_release", 4'b0000, 2'd0, 8'd0);
        goto(2);
        rst = 1'b1;

        // Single L pulse sampled at edge 10.
        expect_at(9, "single_pre", 4'b0000, 2'd0, 8'd0);
        for (int e = 10; e <= 13; e++) expect_at(e, "single_hold", 4'b0001, 2'd0, 8'd1);
        expect_at(14, "single_fall", 4'b0000, 2'd0, 8'd1);
        goto(9);  drive(4'b0001);
        goto(10); drive(4'b0000);

        // R retriggered at edge 23, falls after edge 27.
        for (int e = 20; e <= 22; e++) expect_at(e, "retrig_first", 4'b0010, 2'd1, 8'd2);
        for (int e = 23; e <= 26; e++) expect_at(e, "retrig_second", 4'b0010, 2'd1, 8'd3);
        expect_at(27, "retrig_fall", 4'b0000, 2'd1, 8'd3);
        goto(19); drive(4'b0010);
        goto(20); drive(4'b0000);
        goto(22); drive(4'b0010);
        goto(23); drive(4'b0000);

        // U retriggered on its expiry edge 34, falls after edge 38.
        for (int e = 30; e <= 33; e++) expect_at(e, "expiry_first", 4'b0100, 2'd2, 8'd4);
        for (int e = 34; e <= 37; e++) expect_at(e, "expiry_second", 4'b0100, 2'd2, 8'd5);
        expect_at(38, "expiry_fall", 4'b0000, 2'd2, 8'd5);
        goto(29); drive(4'b0100);
        goto(30); drive(4'b0000);
        goto(33); drive(4'b0100);
        goto(34); drive(4'b0000);

        // L, R, D together at edge 40.
        for (int e = 40; e <= 43; e++) expect_at(e, "simul_hold", 4'b1011, 2'd3, 8'd8);
        expect_at(44, "simul_fall", 4'b0000, 2'd3, 8'd8);
        goto(39); drive(4'b1011);
        goto(40); drive(4'b0000);

        // Asynchronous reset while U is held; a pulse during reset is dropped.
        expect_at(51, "pre_reset_hold", 4'b0100, 2'd2, 8'd9);
        for (int e = 52; e <= 56; e++) expect_at(e, "reset_clear", 4'b0000, 2'd0, 8'd0);
        goto(49); drive(4'b0100);
        goto(50); drive(4'b0000);
        goto(51);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(4'b0001);
        goto(54);
        rst = 1'b1;
        drive(4'b0000);

        // 254 events from a held L, then all four at once: 254 + 4 wraps to 2.
        expect_at(100, "preload_mid", 4'b0001, 2'd0, 8'd41);
        expect_at(313, "preload_end", 4'b0001, 2'd0, 8'd254);
        for (int e = 314; e <= 317; e++) expect_at(e, "wrap_hold", 4'b1111, 2'd3, 8'd2);
        expect_at(318, "wrap_fall", 4'b0000, 2'd3, 8'd2);
        goto(59);  drive(4'b0001);
        goto(313); drive(4'b1111);
        goto(314); drive(4'b0000);

        for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
